// File: rtl/processor_debug_pkg.sv
// processor_debug_pkg: shared types and constants for the processor debug host.
// The optional checksum state exists only when PROCESSOR_DEBUG_CHECKSUM_EN is defined.
package processor_debug_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HEADER,
    ST_SET_ADDR,
    ST_CAPTURE,
    ST_SEND,
    ST_WAIT_CMD,
    ST_RESUME,
    ST_RELEASE
`ifdef PROCESSOR_DEBUG_CHECKSUM_EN
    , ST_CHECKSUM
`endif
  } debug_state_t;

  localparam logic [7:0] DEBUG_FRAME_HEADER = 8'hA5;
  localparam logic [7:0] DEBUG_CMD_CONTINUE = 8'h43;
  localparam logic [7:0] DEBUG_CMD_RESEND   = 8'h52;
  localparam logic [3:0] DEBUG_IP_ADDR      = 4'd8;

  // Byte k of a word already zero-extended to 24 bits; k=3 yields zero.
  function automatic logic [7:0] word_byte(input logic [23:0] w, input logic [1:0] k);
    case (k)
      2'd0:    word_byte = w[7:0];
      2'd1:    word_byte = w[15:8];
      2'd2:    word_byte = w[23:16];
      default: word_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/processor_debug_host_serializer.sv
// debug_word_serializer: holds one captured processor word and walks its three
// little-endian bytes as the sink accepts them. With PROCESSOR_DEBUG_CHECKSUM_EN
// defined it also keeps the running XOR of every data byte accepted since clear.
module debug_word_serializer
  import processor_debug_pkg::*;
#(
  parameter int WORD_SIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WORD_SIZE-1:0] word,
  input  logic                 accept,
  output logic [7:0]           next_byte,
  output logic                 done
`ifdef PROCESSOR_DEBUG_CHECKSUM_EN
  ,
  input  logic                 clear,
  output logic [7:0]           checksum
`endif
);

  logic [23:0] word_q;
  logic [1:0]  byte_cnt;

  // Byte currently on the output is word_byte(word_q, byte_cnt); the owner
  // registers next_byte when the current one is accepted.
  assign done      = accept && (byte_cnt == 2'd2);
  assign next_byte = word_byte(word_q, byte_cnt + 2'd1);

  // Capture the word on load, then advance one byte per accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_q   <= '0;
      byte_cnt <= 2'd0;
    end else if (load) begin
      word_q   <= 24'(word);
      byte_cnt <= 2'd0;
    end else if (accept) begin
      byte_cnt <= done ? 2'd0 : byte_cnt + 2'd1;
    end
  end

`ifdef PROCESSOR_DEBUG_CHECKSUM_EN
  logic [7:0] sum_q;

  // Includes the byte being accepted now, so it is final on the last accept.
  assign checksum = sum_q ^ word_byte(word_q, byte_cnt);

  // Running XOR of data bytes, restarted at each frame header.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      sum_q <= 8'h00;
    end else if (accept) begin
      sum_q <= checksum;
    end
  end
`endif

endmodule

// File: rtl/processor_debug_host.sv
// processor_debug_host: when the processor parks on wait_for_continue, reads
// r0..r(NUM_REGS-1) and ip over the debug port, streams them as a byte frame
// (header A5, then 3 little-endian bytes per word) and releases the processor
// with a one-cycle pulse on a 'C' command; 'R' re-sends the frame.
// Define PROCESSOR_DEBUG_CHECKSUM_EN to append an XOR-of-data-bytes checksum.
//
// Byte stream handshake: tx_data is offered while tx_valid is high and moves
// on only in a cycle where tx_valid && tx_ready; while tx_valid && !tx_ready
// tx_data holds. rx_valid qualifies rx_data for a single cycle, no buffering.
module processor_debug_host
  import processor_debug_pkg::*;
#(
  parameter int WORD_SIZE = 18,
  parameter int NUM_REGS  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wait_for_continue,
  output logic                 wait_continue_execution,
  output logic                 debug_get_param,
  output logic [3:0]           debug_reg_addr,
  input  logic [WORD_SIZE-1:0] debug_data_out,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output debug_state_t         fsm_state
);

  localparam logic [3:0] LAST_REG = 4'(NUM_REGS);

  debug_state_t state;
  logic [3:0]   word_idx;
  logic         ser_load;
  logic         ser_accept;
  logic         ser_done;
  logic [7:0]   ser_next_byte;
`ifdef PROCESSOR_DEBUG_CHECKSUM_EN
  logic         ser_clear;
  logic [7:0]   ser_checksum;
`endif

  assign fsm_state  = state;
  assign ser_load   = (state == ST_CAPTURE);
  assign ser_accept = (state == ST_SEND) && tx_valid && tx_ready;
`ifdef PROCESSOR_DEBUG_CHECKSUM_EN
  assign ser_clear  = (state == ST_HEADER);
`endif

  debug_word_serializer #(
    .WORD_SIZE (WORD_SIZE)
  ) u_serializer (
    .clock     (clock),
    .reset     (reset),
    .load      (ser_load),
    .word      (debug_data_out),
    .accept    (ser_accept),
    .next_byte (ser_next_byte),
    .done      (ser_done)
`ifdef PROCESSOR_DEBUG_CHECKSUM_EN
    ,
    .clear     (ser_clear),
    .checksum  (ser_checksum)
`endif
  );

  // Frame sequencer; every output is registered and set on entry to the state that owns it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                   <= ST_IDLE;
      word_idx                <= 4'd0;
      wait_continue_execution <= 1'b0;
      debug_get_param         <= 1'b0;
      debug_reg_addr          <= 4'd0;
      tx_data                 <= 8'h00;
      tx_valid                <= 1'b0;
    end else begin
      wait_continue_execution <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wait_for_continue) begin
            state    <= ST_HEADER;
            word_idx <= 4'd0;
            tx_valid <= 1'b1;
            tx_data  <= DEBUG_FRAME_HEADER;
          end
        end
        ST_HEADER: begin
          if (tx_ready) begin
            state           <= ST_SET_ADDR;
            tx_valid        <= 1'b0;
            tx_data         <= 8'h00;
            debug_get_param <= 1'b1;
            debug_reg_addr  <= word_idx;
          end
        end
        ST_SET_ADDR: begin
          // Address has been on the bus one cycle; data is sampled at the end of CAPTURE.
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state           <= ST_SEND;
          debug_get_param <= 1'b0;
          tx_valid        <= 1'b1;
          tx_data         <= debug_data_out[7:0];
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (!ser_done) begin
              tx_data <= ser_next_byte;
            end else if (word_idx < LAST_REG) begin
              state           <= ST_SET_ADDR;
              word_idx        <= word_idx + 4'd1;
              tx_valid        <= 1'b0;
              tx_data         <= 8'h00;
              debug_get_param <= 1'b1;
              debug_reg_addr  <= word_idx + 4'd1;
            end else begin
`ifdef PROCESSOR_DEBUG_CHECKSUM_EN
              state   <= ST_CHECKSUM;
              tx_data <= ser_checksum;
`else
              state    <= ST_WAIT_CMD;
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
`endif
            end
          end
        end
`ifdef PROCESSOR_DEBUG_CHECKSUM_EN
        ST_CHECKSUM: begin
          if (tx_ready) begin
            state    <= ST_WAIT_CMD;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
          end
        end
`endif
        ST_WAIT_CMD: begin
          if (rx_valid && rx_data == DEBUG_CMD_CONTINUE) begin
            state                   <= ST_RESUME;
            wait_continue_execution <= 1'b1;
          end else if (rx_valid && rx_data == DEBUG_CMD_RESEND) begin
            state    <= ST_HEADER;
            word_idx <= 4'd0;
            tx_valid <= 1'b1;
            tx_data  <= DEBUG_FRAME_HEADER;
          end
        end
        ST_RESUME: begin
          // The pulse was raised on entry and is cleared by the default above.
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Hold off until the processor leaves this halt, so it is dumped once.
          if (!wait_for_continue) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_processor_debug_host.sv
// tb_processor_debug_host: self-checking bench for processor_debug_host.
// Honours PROCESSOR_DEBUG_CHECKSUM_EN the same way as the design.
module tb_processor_debug_host;
  import processor_debug_pkg::*;

  localparam int WORD_SIZE = 18;
  localparam int NUM_REGS  = 8;
`ifdef PROCESSOR_DEBUG_CHECKSUM_EN
  localparam int FRAME_LEN = 29;
`else
  localparam int FRAME_LEN = 28;
`endif

  logic                 clock;
  logic                 reset;
  logic                 wait_for_continue;
  logic                 wait_continue_execution;
  logic                 debug_get_param;
  logic [3:0]           debug_reg_addr;
  logic [WORD_SIZE-1:0] debug_data_out;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  debug_state_t         fsm_state;

  processor_debug_host #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_REGS  (NUM_REGS)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .wait_for_continue       (wait_for_continue),
    .wait_continue_execution (wait_continue_execution),
    .debug_get_param         (debug_get_param),
    .debug_reg_addr          (debug_reg_addr),
    .debug_data_out          (debug_data_out),
    .tx_data                 (tx_data),
    .tx_valid                (tx_valid),
    .tx_ready                (tx_ready),
    .rx_data                 (rx_data),
    .rx_valid                (rx_valid),
    .fsm_state               (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [3:0] addr_q[$];
  logic bp_en = 1'b0;

  // ---------------- processor model (one-cycle debug read latency) ----------------
  logic [WORD_SIZE-1:0] regs [NUM_REGS+1];
  logic [WORD_SIZE-1:0] dbg_q;
  always @(posedge clock)
    dbg_q <= (debug_reg_addr <= DEBUG_IP_ADDR) ? regs[debug_reg_addr] : '0;
  assign debug_data_out = dbg_q;

  // ---------------- sink ready driver ----------------
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor (away from the active edge) ----------------
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_gp    = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_gp    = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!tx_valid || tx_data !== prev_data) begin
          failures++;
          $display("FAIL stall_hold got valid=%0b data=%02h exp valid=1 data=%02h", tx_valid, tx_data, prev_data);
        end
      end
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (wait_continue_execution) pulse_cnt++;
      if (debug_get_param && !prev_gp) addr_q.push_back(debug_reg_addr);
      prev_gp = debug_get_param;
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    idle(1);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic wait_bytes(input int n, input int budget, input string name);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      idle(1);
      c++;
    end
    if (got_q.size() < n) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=%0d bytes exp=%0d", name, got_q.size(), n);
    end
  endtask

  task automatic check_frame(input string name);
    int bad = -1;
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      if (bad < 0 && got_q[k] !== exp_q[k]) bad = k;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_bytes idx=%0d got=%02h exp=%02h", name, bad, got_q[bad], exp_q[bad]);
    end
  endtask

  task automatic check_addrs(input string name);
    int bad = -1;
    check({name, "_addr_len"}, addr_q.size(), NUM_REGS + 1);
    for (int k = 0; k < addr_q.size(); k++)
      if (bad < 0 && addr_q[k] !== 4'(k)) bad = k;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_addr_seq idx=%0d got=%0d exp=%0d", name, bad, addr_q[bad], bad);
    end
  endtask

  // Reference frame: header, each word as 3 little-endian bytes, optional XOR.
  function automatic void build_frame();
    logic [7:0] x;
    logic [7:0] v;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    x = 8'h00;
    for (int k = 0; k <= NUM_REGS; k++) begin
      for (int b = 0; b < 3; b++) begin
        v = 8'((32'(regs[k]) >> (8 * b)) & 32'hFF);
        exp_q.push_back(v);
        x = x ^ v;
      end
    end
`ifdef PROCESSOR_DEBUG_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  function automatic void clear_obs();
    got_q.delete();
    addr_q.delete();
    pulse_cnt = 0;
  endfunction

  // ---------------- command table ----------------
  typedef struct {
    logic [7:0] rx;
    int         exp_pulses;
    int         exp_bytes;
  } cmd_vec_t;

  cmd_vec_t cmd_tab[6];
  logic [7:0] gold[28];

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    cmd_tab[0] = '{8'h00, 0, 0};
    cmd_tab[1] = '{8'h41, 0, 0};
    cmd_tab[2] = '{8'h63, 0, 0};
    cmd_tab[3] = '{8'h52, 0, FRAME_LEN};
    cmd_tab[4] = '{8'hFF, 0, 0};
    cmd_tab[5] = '{8'h43, 1, 0};

    gold = '{8'hA5,
             8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00,
             8'h04, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00,
             8'h07, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h03};

    reset = 1'b1;
    wait_for_continue = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) regs[k] = WORD_SIZE'(k + 1);
    regs[DEBUG_IP_ADDR] = 18'h3FFFF;

    // Reset values
    idle(3);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_pulse", 32'(wait_continue_execution), 0);
    check("rst_get_param", 32'(debug_get_param), 0);
    check("rst_reg_addr", 32'(debug_reg_addr), 0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    reset = 1'b0;
    idle(2);

    // Dump with a known register file
    exp_q.delete();
    for (int k = 0; k < 28; k++) exp_q.push_back(gold[k]);
`ifdef PROCESSOR_DEBUG_CHECKSUM_EN
    exp_q.push_back(8'h0B);
`endif
    clear_obs();
    wait_for_continue = 1'b1;
    wait_bytes(FRAME_LEN, 400, "dump");
    idle(10);
    check_frame("dump");
    check_addrs("dump");
    check("dump_no_pulse", pulse_cnt, 0);

    // Commands in WAIT_CMD: junk ignored, 'R' resends, 'C' pulses once
    for (int t = 0; t < 6; t++) begin
      clear_obs();
      send_rx(cmd_tab[t].rx);
      if (cmd_tab[t].exp_bytes > 0) wait_bytes(cmd_tab[t].exp_bytes, 400, "cmd_resend");
      idle(40);
      check($sformatf("cmd%0d_bytes", t), got_q.size(), cmd_tab[t].exp_bytes);
      check($sformatf("cmd%0d_pulses", t), pulse_cnt, cmd_tab[t].exp_pulses);
      if (cmd_tab[t].exp_bytes > 0) check_frame($sformatf("cmd%0d_resend", t));
    end
    wait_for_continue = 1'b0;
    idle(3);

    // Random register files with random backpressure; corner cases on some passes
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k <= NUM_REGS; k++) regs[k] = WORD_SIZE'($urandom);
      if (it == 3) regs[DEBUG_IP_ADDR] = '1;
      build_frame();
      clear_obs();
      bp_en = 1'b1;
      wait_for_continue = 1'b1;
      if (it == 1) begin
        wait_bytes(6, 400, "rand_midc");
        send_rx(DEBUG_CMD_CONTINUE);
      end
      if (it == 2) begin
        wait_bytes(8, 400, "rand_drop");
        wait_for_continue = 1'b0;
      end
      wait_bytes(FRAME_LEN, 2000, $sformatf("rand%0d", it));
      idle(5);
      check_frame($sformatf("rand%0d", it));
      check_addrs($sformatf("rand%0d", it));
      check($sformatf("rand%0d_no_pulse", it), pulse_cnt, 0);
      send_rx(DEBUG_CMD_CONTINUE);
      idle(4);
      check($sformatf("rand%0d_pulse", it), pulse_cnt, 1);
      wait_for_continue = 1'b0;
      idle(3);
    end
    bp_en = 1'b0;
    idle(2);

    // Reset mid-frame, then a fresh halt yields a full frame
    build_frame();
    clear_obs();
    wait_for_continue = 1'b1;
    wait_bytes(10, 400, "rst_mid");
    reset = 1'b1;
    idle(1);
    check("midrst_tx_valid", 32'(tx_valid), 0);
    check("midrst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("midrst_pulse", 32'(wait_continue_execution), 0);
    reset = 1'b0;
    clear_obs();
    wait_bytes(FRAME_LEN, 400, "after_rst");
    idle(5);
    check_frame("after_rst");
    check_addrs("after_rst");
    send_rx(DEBUG_CMD_CONTINUE);
    idle(4);
    check("after_rst_pulse", pulse_cnt, 1);
    wait_for_continue = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
